hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter NB_ADDR, default 5: register-address width.
REQ-002 Parameter NB_CNT, default 16: stall-counter width.
REQ-003 i_clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous and active-low.
REQ-005 i_enable  input  1  pipeline advance; 0 freezes all state (debug step/halt).
REQ-006 i_issue_valid  input  1  ID holds a valid instruction.
REQ-007 i_rs_id, i_rt_id  input  NB_ADDR each  ID source registers.
REQ-008 i_use_rs, i_use_rt  input  1 each  ID instruction reads rs / rt.
REQ-009 i_branch_id  input  1  ID instruction resolves a branch in ID and needs operands this cycle.
REQ-010 i_rd_id  input  NB_ADDR  ID destination register.
REQ-011 i_regWrite_id, i_memRead_id  input  1 each  ID instruction writes a register / is a load.
REQ-012 i_flush_id  input  1  squash the ID instruction (taken branch/jump).
REQ-013 o_stall  output  1  hold PC and IF/ID; insert bubble into EX.
REQ-014 o_pending  output  2^NB_ADDR  bit r = 1 while a write to register r is in flight.
REQ-015 o_rd_ex, o_rd_m, o_rd_wb  output  NB_ADDR each  destination tags of the in-flight stages.
REQ-016 o_regWrite_ex, o_regWrite_m, o_regWrite_wb  output  1 each  qualified write-enable of each stage tag.
REQ-017 o_stall_count  output  NB_CNT  number of stall cycles since reset.

Function
REQ-018 The block SHALL hold a three-entry tag pipeline EX, M, WB; each entry = {valid, regWrite, memRead, rd}.
REQ-019 When i_enable=1, M<-EX and WB<-M on each edge; EX<-ID tag, or an invalid entry if o_stall=1, i_flush_id=1 or i_issue_valid=0.
REQ-020 When i_enable=0, all entries and the counter SHALL hold.
REQ-021 A tag with rd=0 SHALL be stored with regWrite=0; register 0 is never pending and never causes a stall.
REQ-022 match(S,x) = S.valid & S.regWrite & S.rd==x; src hit = (i_use_rs & match(S,i_rs_id)) | (i_use_rt & match(S,i_rt_id)).
REQ-023 Load-use: o_stall=1 if EX.memRead and src hit on EX.
REQ-024 Branch hazard: o_stall=1 if i_branch_id and (src hit on EX, or M.memRead and src hit on M).
REQ-025 o_stall SHALL be combinational from current entries and ID inputs (zero latency), gated by i_issue_valid & ~i_flush_id.
REQ-026 A stall SHALL persist only until the hazard clears (load-use: exactly 1 cycle; branch after load: 2 cycles).
REQ-027 o_pending[r] SHALL be the OR of match(S,r) over EX, M, WB; multiple in-flight writes to one register keep the bit set until the last leaves WB.
REQ-028 o_rd_*/o_regWrite_* SHALL be registered and reflect entries directly; o_regWrite_* = valid & regWrite.
REQ-029 o_stall_count SHALL increment on each edge with i_enable=1 and o_stall=1, saturating at all-ones.
REQ-030 Simultaneous stall and flush: flush wins; no stall, bubble into EX, counter unchanged.

Reset
REQ-031 While i_rst_n=0: all entries invalid, rd=0, o_pending=0, o_stall=0, o_stall_count=0, independent of i_clk.
REQ-032 Reset asserted mid-stall SHALL discard all in-flight tags; first post-reset cycle sees an empty scoreboard.

Structure
REQ-033 The tag-entry record type, NB_ADDR and the register-0 constant SHALL live in the shared pipeline package.
REQ-034 One sub-module, hazard_tag_stage (one pipeline entry register with enable and bubble-insert), SHALL be instantiated three times.

Verification
REQ-035 lw $2 then add $3,$2,$4 (use_rs) -> o_stall=1 for exactly 1 cycle, o_stall_count=1, EX bubble.
REQ-036 add $5 then beq $5,$6 -> 1 stall cycle; lw $5 then beq $5,$6 -> 2 stall cycles, count=2.
REQ-037 Writes to $7 in back-to-back cycles -> o_pending[7]=1 for 4 cycles, clears after the second leaves WB.
REQ-038 lw $0 then add using $0 -> o_stall=0, o_pending=0.
REQ-039 Load-use hazard with i_flush_id=1 -> o_stall=0, count unchanged; i_enable=0 for 5 cycles -> all outputs frozen.
REQ-040 i_rst_n pulled low asynchronously mid-stall -> o_stall=0, o_pending=0, count=0 before the next edge.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline definitions for the hazard scoreboard: tag-entry record, address width
// and the hard-wired zero register.
package hazard_scoreboard_pkg;

    localparam int unsigned NB_ADDR = 5;

    localparam logic [NB_ADDR-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic               valid;
        logic               reg_write;
        logic               mem_read;
        logic [NB_ADDR-1:0] rd;
    } tag_t;

    localparam tag_t TAG_BUBBLE = '0;

    function automatic logic tag_match(input tag_t t, input logic [NB_ADDR-1:0] r);
        return t.valid & t.reg_write & (t.rd == r);
    endfunction

endpackage

// File: rtl/hazard_tag_stage.sv
// One entry of the in-flight destination-tag pipeline: loads on enable, or a bubble on request.
module hazard_tag_stage
    import hazard_scoreboard_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_enable,
    input  logic i_bubble,
    input  tag_t i_tag,
    output tag_t o_tag
);

    tag_t tag_d, tag_q;

    always_comb begin
        tag_d = tag_q;
        if (i_enable) begin
            tag_d = i_bubble ? TAG_BUBBLE : i_tag;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tag_q <= TAG_BUBBLE;
        end else begin
            tag_q <= tag_d;
        end
    end

    assign o_tag = tag_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Register-write scoreboard for a 5-stage pipeline: tracks in-flight destination tags and
// raises a zero-latency stall for load-use and ID-resolved branch hazards.
module hazard_scoreboard #(
    parameter int unsigned NB_ADDR = 5,
    parameter int unsigned NB_CNT  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_enable,
    input  logic                  i_issue_valid,
    input  logic [NB_ADDR-1:0]    i_rs_id,
    input  logic [NB_ADDR-1:0]    i_rt_id,
    input  logic                  i_use_rs,
    input  logic                  i_use_rt,
    input  logic                  i_branch_id,
    input  logic [NB_ADDR-1:0]    i_rd_id,
    input  logic                  i_regWrite_id,
    input  logic                  i_memRead_id,
    input  logic                  i_flush_id,
    output logic                  o_stall,
    output logic [2**NB_ADDR-1:0] o_pending,
    output logic [NB_ADDR-1:0]    o_rd_ex,
    output logic [NB_ADDR-1:0]    o_rd_m,
    output logic [NB_ADDR-1:0]    o_rd_wb,
    output logic                  o_regWrite_ex,
    output logic                  o_regWrite_m,
    output logic                  o_regWrite_wb,
    output logic [NB_CNT-1:0]     o_stall_count
);

    // NB_ADDR here must equal the package width the tag record is built from.
    import hazard_scoreboard_pkg::*;

    tag_t id_tag;
    tag_t ex_tag;
    tag_t m_tag;
    tag_t wb_tag;

    logic id_active;
    logic hit_ex;
    logic hit_m;
    logic load_use;
    logic branch_haz;
    logic stall;
    logic ex_bubble;

    logic [NB_CNT-1:0] cnt_d, cnt_q;

    // Writes to register 0 are dropped at entry so r0 can never look pending.
    always_comb begin
        id_tag           = TAG_BUBBLE;
        id_tag.valid     = 1'b1;
        id_tag.reg_write = i_regWrite_id & (i_rd_id != REG_ZERO);
        id_tag.mem_read  = i_memRead_id;
        id_tag.rd        = i_rd_id;
    end

    always_comb begin
        id_active  = i_issue_valid & ~i_flush_id;
        hit_ex     = (i_use_rs & tag_match(ex_tag, i_rs_id)) |
                     (i_use_rt & tag_match(ex_tag, i_rt_id));
        hit_m      = (i_use_rs & tag_match(m_tag, i_rs_id)) |
                     (i_use_rt & tag_match(m_tag, i_rt_id));
        load_use   = ex_tag.mem_read & hit_ex;
        // Branches compare in ID, so an ALU result in EX or a load still in M is too late.
        branch_haz = i_branch_id & (hit_ex | (m_tag.mem_read & hit_m));
        stall      = id_active & (load_use | branch_haz);
        ex_bubble  = stall | ~id_active;
    end

    hazard_tag_stage u_stage_ex (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_enable (i_enable),
        .i_bubble (ex_bubble),
        .i_tag    (id_tag),
        .o_tag    (ex_tag)
    );

    hazard_tag_stage u_stage_m (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_enable (i_enable),
        .i_bubble (1'b0),
        .i_tag    (ex_tag),
        .o_tag    (m_tag)
    );

    hazard_tag_stage u_stage_wb (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_enable (i_enable),
        .i_bubble (1'b0),
        .i_tag    (m_tag),
        .o_tag    (wb_tag)
    );

    always_comb begin
        o_pending = '0;
        for (int r = 0; r < 2**NB_ADDR; r++) begin
            o_pending[r] = tag_match(ex_tag, NB_ADDR'(r)) |
                           tag_match(m_tag,  NB_ADDR'(r)) |
                           tag_match(wb_tag, NB_ADDR'(r));
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (i_enable && stall && (cnt_q != {NB_CNT{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_stall       = stall;
    assign o_stall_count = cnt_q;
    assign o_rd_ex       = ex_tag.rd;
    assign o_rd_m        = m_tag.rd;
    assign o_rd_wb       = wb_tag.rd;
    assign o_regWrite_ex = ex_tag.valid & ex_tag.reg_write;
    assign o_regWrite_m  = m_tag.valid & m_tag.reg_write;
    assign o_regWrite_wb = wb_tag.valid & wb_tag.reg_write;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a per-cycle instruction table plus hand-written
// freeze and asynchronous-reset sequences.
module tb_hazard_scoreboard;

    localparam int unsigned NB_ADDR = 5;
    localparam int unsigned NB_CNT  = 16;

    logic                  i_clk;
    logic                  i_rst_n;
    logic                  i_enable;
    logic                  i_issue_valid;
    logic [NB_ADDR-1:0]    i_rs_id;
    logic [NB_ADDR-1:0]    i_rt_id;
    logic                  i_use_rs;
    logic                  i_use_rt;
    logic                  i_branch_id;
    logic [NB_ADDR-1:0]    i_rd_id;
    logic                  i_regWrite_id;
    logic                  i_memRead_id;
    logic                  i_flush_id;
    logic                  o_stall;
    logic [2**NB_ADDR-1:0] o_pending;
    logic [NB_ADDR-1:0]    o_rd_ex;
    logic [NB_ADDR-1:0]    o_rd_m;
    logic [NB_ADDR-1:0]    o_rd_wb;
    logic                  o_regWrite_ex;
    logic                  o_regWrite_m;
    logic                  o_regWrite_wb;
    logic [NB_CNT-1:0]     o_stall_count;

    hazard_scoreboard #(
        .NB_ADDR (NB_ADDR),
        .NB_CNT  (NB_CNT)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_enable      (i_enable),
        .i_issue_valid (i_issue_valid),
        .i_rs_id       (i_rs_id),
        .i_rt_id       (i_rt_id),
        .i_use_rs      (i_use_rs),
        .i_use_rt      (i_use_rt),
        .i_branch_id   (i_branch_id),
        .i_rd_id       (i_rd_id),
        .i_regWrite_id (i_regWrite_id),
        .i_memRead_id  (i_memRead_id),
        .i_flush_id    (i_flush_id),
        .o_stall       (o_stall),
        .o_pending     (o_pending),
        .o_rd_ex       (o_rd_ex),
        .o_rd_m        (o_rd_m),
        .o_rd_wb       (o_rd_wb),
        .o_regWrite_ex (o_regWrite_ex),
        .o_regWrite_m  (o_regWrite_m),
        .o_regWrite_wb (o_regWrite_wb),
        .o_stall_count (o_stall_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic        iv;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        ur;
        logic        ut;
        logic        br;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        fl;
        logic        exp_stall;
        logic [31:0] exp_pend;
        logic [15:0] exp_cnt;
        logic [4:0]  exp_rd_ex;
        logic        exp_rw_ex;
    } vec_t;

    vec_t vecs[$];
    int   n_checks;
    int   n_fail;

    function automatic vec_t mk(input logic iv, input int rs, input int rt, input logic ur,
                                input logic ut, input logic br, input int rd, input logic rw,
                                input logic mr, input logic fl, input logic st,
                                input logic [31:0] pend, input int cnt, input int rdex,
                                input logic rwex);
        vec_t v;
        v.iv = iv; v.rs = 5'(rs); v.rt = 5'(rt); v.ur = ur; v.ut = ut; v.br = br;
        v.rd = 5'(rd); v.rw = rw; v.mr = mr; v.fl = fl;
        v.exp_stall = st; v.exp_pend = pend; v.exp_cnt = 16'(cnt);
        v.exp_rd_ex = 5'(rdex); v.exp_rw_ex = rwex;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input int rs, input int rt, input logic ur,
                         input logic ut, input logic br, input int rd, input logic rw,
                         input logic mr, input logic fl);
        i_issue_valid = iv; i_rs_id = 5'(rs); i_rt_id = 5'(rt); i_use_rs = ur;
        i_use_rt = ut; i_branch_id = br; i_rd_id = 5'(rd); i_regWrite_id = rw;
        i_memRead_id = mr; i_flush_id = fl;
    endtask

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        i_rst_n  = 1'b0;
        i_enable = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Cycle-by-cycle program; expectations describe the state before each edge.
        //             iv rs rt ur ut br rd rw mr fl | st pend       cnt rdex rwex
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 2, 1, 1, 0,  0, 32'h0,     0, 0, 0)); // lw $2
        vecs.push_back(mk(1, 2, 4, 1, 1, 0, 3, 1, 0, 0,  1, 32'h4,     0, 2, 1)); // add $3,$2
        vecs.push_back(mk(1, 2, 4, 1, 1, 0, 3, 1, 0, 0,  0, 32'h4,     1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'hC,     1, 3, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 5, 1, 0, 0,  0, 32'h8,     1, 0, 0)); // add $5
        vecs.push_back(mk(1, 5, 6, 1, 1, 1, 0, 0, 0, 0,  1, 32'h28,    1, 5, 1)); // beq $5,$6
        vecs.push_back(mk(1, 5, 6, 1, 1, 1, 0, 0, 0, 0,  0, 32'h20,    2, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 5, 1, 1, 0,  0, 32'h20,    2, 0, 0)); // lw $5
        vecs.push_back(mk(1, 5, 6, 1, 1, 1, 0, 0, 0, 0,  1, 32'h20,    2, 5, 1)); // beq $5,$6
        vecs.push_back(mk(1, 5, 6, 1, 1, 1, 0, 0, 0, 0,  1, 32'h20,    3, 0, 0));
        vecs.push_back(mk(1, 5, 6, 1, 1, 1, 0, 0, 0, 0,  0, 32'h20,    4, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 7, 1, 0, 0,  0, 32'h0,     4, 0, 0)); // add $7
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 7, 1, 0, 0,  0, 32'h80,    4, 7, 1)); // add $7
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'h80,    4, 7, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'h80,    4, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'h80,    4, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0,  0, 32'h0,     4, 0, 0)); // lw $0
        vecs.push_back(mk(1, 0, 0, 1, 1, 0, 8, 1, 0, 0,  0, 32'h0,     4, 0, 0)); // add $8,$0,$0
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 9, 1, 1, 0,  0, 32'h100,   4, 8, 1)); // lw $9
        vecs.push_back(mk(1, 9, 0, 1, 0, 0, 10, 1, 0, 1, 0, 32'h300,   4, 9, 1)); // flushed use
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'h300,   4, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'h200,   4, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 11, 1, 1, 0, 0, 32'h0,     4, 0, 0)); // lw $11
        vecs.push_back(mk(1, 1, 11, 1, 1, 0, 12, 1, 0, 0, 1, 32'h800,  4, 11, 1)); // rt use
        vecs.push_back(mk(1, 1, 11, 1, 1, 0, 12, 1, 0, 0, 0, 32'h800,  5, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 13, 1, 1, 0, 0, 32'h1800,  5, 12, 1)); // lw $13
        vecs.push_back(mk(1, 13, 13, 0, 0, 0, 14, 1, 0, 0, 0, 32'h3000, 5, 13, 1)); // no use
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'h7000,  5, 14, 1));

        next_cycle();
        next_cycle();
        // Reset state, still in reset
        chk("rst_stall", 0, 32'(o_stall), 32'h0);
        chk("rst_pending", 0, o_pending, 32'h0);
        chk("rst_count", 0, 32'(o_stall_count), 32'h0);
        chk("rst_rd_ex", 0, 32'(o_rd_ex), 32'h0);
        chk("rst_rw_wb", 0, 32'(o_regWrite_wb), 32'h0);
        i_rst_n = 1'b1;

        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].iv, int'(vecs[k].rs), int'(vecs[k].rt), vecs[k].ur, vecs[k].ut,
                  vecs[k].br, int'(vecs[k].rd), vecs[k].rw, vecs[k].mr, vecs[k].fl);
            #2;
            chk("stall", k, 32'(o_stall), 32'(vecs[k].exp_stall));
            chk("pending", k, o_pending, vecs[k].exp_pend);
            chk("count", k, 32'(o_stall_count), 32'(vecs[k].exp_cnt));
            chk("rd_ex", k, 32'(o_rd_ex), 32'(vecs[k].exp_rd_ex));
            chk("rw_ex", k, 32'(o_regWrite_ex), 32'(vecs[k].exp_rw_ex));
            next_cycle();
        end

        // Freeze: hold a load-use hazard with enable low for 5 cycles
        i_rst_n = 1'b0;
        #2;
        i_rst_n = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 2, 1, 1, 0);
        next_cycle();
        drive(1, 2, 0, 1, 0, 0, 3, 1, 0, 0);
        i_enable = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #2;
            chk("frz_stall", c, 32'(o_stall), 32'h1);
            chk("frz_count", c, 32'(o_stall_count), 32'h0);
            chk("frz_rd_ex", c, 32'(o_rd_ex), 32'h2);
            chk("frz_pending", c, o_pending, 32'h4);
            chk("frz_rd_m", c, 32'(o_rd_m), 32'h0);
            next_cycle();
        end
        i_enable = 1'b1;
        next_cycle();
        chk("thaw_count", 0, 32'(o_stall_count), 32'h1);
        chk("thaw_rd_m", 0, 32'(o_rd_m), 32'h2);
        chk("thaw_rw_m", 0, 32'(o_regWrite_m), 32'h1);
        chk("thaw_rw_ex", 0, 32'(o_regWrite_ex), 32'h0);
        chk("thaw_stall", 0, 32'(o_stall), 32'h0);

        // Asynchronous reset mid-stall
        drive(1, 0, 0, 0, 0, 0, 4, 1, 1, 0);
        next_cycle();
        chk("pre_rd_wb", 0, 32'(o_rd_wb), 32'h2);
        drive(1, 4, 0, 1, 0, 0, 5, 1, 0, 0);
        #2;
        chk("arst_pre_stall", 0, 32'(o_stall), 32'h1);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("arst_stall", 0, 32'(o_stall), 32'h0);
        chk("arst_pending", 0, o_pending, 32'h0);
        chk("arst_count", 0, 32'(o_stall_count), 32'h0);
        chk("arst_rd_ex", 0, 32'(o_rd_ex), 32'h0);
        chk("arst_rd_wb", 0, 32'(o_rd_wb), 32'h0);
        next_cycle();
        i_rst_n = 1'b1;
        #2;
        chk("post_rst_stall", 0, 32'(o_stall), 32'h0);
        chk("post_rst_pending", 0, o_pending, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
